// File: rtl/spi_cmd_sched.sv
// SPI command scheduler: decodes command words, triggers one of three measurement
// subsystems and returns its result, a status word or an error word for readback.
module spi_cmd_sched #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
    parameter int unsigned MIN_WAIT       = 2
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] cmd_in,
    input  logic        cmd_valid,
    output logic [31:0] sub_cmd,
    output logic [2:0]  sub_trig,
    input  logic [2:0]  sub_busy,
    input  logic [31:0] sub_value0,
    input  logic [31:0] sub_value1,
    input  logic [31:0] sub_value2,
    output logic [31:0] rsp_value,
    output logic        rsp_done,
    output logic        sched_busy
);

    localparam logic [15:0] MIN_WAIT_W = 16'(MIN_WAIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;

    stateT       state, nextState;
    logic [1:0]  sel;
    logic [15:0] waitCnt;
    logic [7:0]  timeoutCnt, overrunCnt, badcmdCnt;

    logic [3:0]  opcode;
    logic        isStatus, isBad;
    logic [1:0]  routeSel;
    logic        selBusy;
    logic [31:0] selValue;
    logic        waitDone, waitTimeout;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        opcode   = cmd_in[31:28];
        isStatus = (opcode == 4'd0);
        isBad    = opcode[3];
        routeSel = 2'd0;
        if (opcode >= 4'd6)
            routeSel = 2'd2;
        else if (opcode >= 4'd4)
            routeSel = 2'd1;

        selBusy  = sub_busy[2];
        selValue = sub_value2;
        case (sel)
            2'd0: begin selBusy = sub_busy[0]; selValue = sub_value0; end
            2'd1: begin selBusy = sub_busy[1]; selValue = sub_value1; end
            default: ;
        endcase

        // completion is checked first wherever both could fire, so it wins
        waitDone    = (waitCnt >= MIN_WAIT_W) && !selBusy;
        waitTimeout = (waitCnt >= TIMEOUT_CYCLES) && selBusy;
    end

    always_ff @(posedge clk) begin
        if (rest)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState  = state;
        sub_trig   = 3'b000;
        rsp_done   = 1'b0;
        sched_busy = (state != IDLE);
        case (state)
            IDLE: begin
                if (cmd_valid)
                    nextState = (isStatus || isBad) ? DONE : ISSUE;
            end
            ISSUE: begin
                nextState = WAIT;
                case (sel)
                    2'd0:    sub_trig = 3'b001;
                    2'd1:    sub_trig = 3'b010;
                    default: sub_trig = 3'b100;
                endcase
            end
            WAIT: begin
                if (waitDone || waitTimeout)
                    nextState = DONE;
            end
            DONE: begin
                rsp_done  = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            sub_cmd    <= '0;
            rsp_value  <= '0;
            sel        <= '0;
            waitCnt    <= '0;
            timeoutCnt <= '0;
            overrunCnt <= '0;
            badcmdCnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (isStatus) begin
                            rsp_value <= {8'h00, timeoutCnt, overrunCnt, badcmdCnt};
                            if (cmd_in[0]) begin
                                timeoutCnt <= '0;
                                overrunCnt <= '0;
                                badcmdCnt  <= '0;
                            end
                        end else if (isBad) begin
                            rsp_value <= {16'hBADC, 12'h000, opcode};
                            badcmdCnt <= satInc(badcmdCnt);
                        end else begin
                            sub_cmd <= cmd_in;
                            sel     <= routeSel;
                        end
                    end
                end
                ISSUE: waitCnt <= 16'd1;
                WAIT: begin
                    if (waitDone) begin
                        rsp_value <= selValue;
                    end else if (waitTimeout) begin
                        rsp_value  <= {16'hDEAD, 14'h0000, sel};
                        timeoutCnt <= satInc(timeoutCnt);
                    end else begin
                        waitCnt <= waitCnt + 16'd1;
                    end
                end
                default: ;
            endcase

            if (cmd_valid && state != IDLE)
                overrunCnt <= satInc(overrunCnt);
        end
    end

endmodule

// File: tb/tb_spi_cmd_sched.sv
// Self-checking bench for spi_cmd_sched: scoreboard of expected readback words
// plus per-scenario checks of trigger, latency, counters and reset behaviour.
module tb_spi_cmd_sched;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic [31:0] cmd_in = '0;
    logic        cmd_valid = 1'b0;
    logic [31:0] sub_cmd;
    logic [2:0]  sub_trig;
    logic [2:0]  sub_busy = '0;
    logic [31:0] sub_value0 = '0, sub_value1 = '0, sub_value2 = '0;
    logic [31:0] rsp_value;
    logic        rsp_done;
    logic        sched_busy;

    int nChecks = 0;
    int nFails  = 0;
    int nDone   = 0;
    logic [31:0] expQ[$];
    logic [7:0]  mTimeout = '0, mOverrun = '0, mBad = '0;

    always #5 clk = ~clk;

    spi_cmd_sched #(.TIMEOUT_CYCLES(16'd16), .MIN_WAIT(2)) dut (
        .clk(clk), .rest(rest), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
        .sub_cmd(sub_cmd), .sub_trig(sub_trig), .sub_busy(sub_busy),
        .sub_value0(sub_value0), .sub_value1(sub_value1), .sub_value2(sub_value2),
        .rsp_value(rsp_value), .rsp_done(rsp_done), .sched_busy(sched_busy)
    );

    // Scoreboard: every response pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rsp_done === 1'b1) begin
            nDone++;
            nChecks++;
            if (expQ.size() == 0) begin
                nFails++;
                $display("FAIL rsp_unexpected: got %h expected no response", rsp_value);
            end else begin
                logic [31:0] e;
                e = expQ.pop_front();
                if (rsp_value !== e) begin
                    nFails++;
                    $display("FAIL rsp_value: got %h expected %h", rsp_value, e);
                end
            end
        end
    end

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic sendCmd(input logic [31:0] c);
        @(negedge clk);
        cmd_in    = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sched_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic statusRead(input bit clr);
        expQ.push_back({8'h00, mTimeout, mOverrun, mBad});
        if (clr) begin
            mTimeout = '0;
            mOverrun = '0;
            mBad     = '0;
        end
        sendCmd({31'h0, clr});
    endtask

    task automatic test_reset;
        bit ok;
        rest      = 1'b1;
        cmd_in    = 32'hA000_0000;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        nChecks++;
        if ({sub_cmd, rsp_value} !== 64'h0) begin
            nFails++;
            $display("FAIL reset_words: got %h/%h expected 0/0", sub_cmd, rsp_value);
        end
        nChecks++;
        if ({sub_trig, rsp_done, sched_busy} !== 5'b0) begin
            nFails++;
            $display("FAIL reset_ctrl: got %b expected 00000", {sub_trig, rsp_done, sched_busy});
        end
        rest = 1'b0;
        statusRead(1'b0);
        waitIdle(10, ok);
        nChecks++;
        if (!ok) begin nFails++; $display("FAIL reset_idle: got busy expected idle"); end
    endtask

    task automatic test_routed;
        bit ok;
        int d0;
        d0 = nDone;
        sub_value1 = 32'h0001_2345;
        expQ.push_back(32'h0001_2345);
        sendCmd(32'h4000_0012);
        nChecks++;
        if (sub_trig !== 3'b010) begin nFails++; $display("FAIL routed_trig: got %b expected 010", sub_trig); end
        nChecks++;
        if (sub_cmd !== 32'h4000_0012) begin nFails++; $display("FAIL routed_cmd: got %h expected 40000012", sub_cmd); end
        sub_busy = 3'b010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nChecks++;
            if (sub_trig !== 3'b000 || sched_busy !== 1'b1) begin
                nFails++;
                $display("FAIL routed_wait: got trig %b busy %b expected 000 1", sub_trig, sched_busy);
            end
        end
        sub_busy = 3'b000;
        waitIdle(20, ok);
        nChecks++;
        if (!ok || nDone - d0 != 1) begin
            nFails++;
            $display("FAIL routed_done: got %0d pulses expected 1", nDone - d0);
        end
    endtask

    task automatic test_min_wait;
        logic [3:0]  ops[4]  = '{4'd1, 4'd3, 4'd5, 4'd7};
        logic [2:0]  trg[4]  = '{3'b001, 3'b001, 3'b010, 3'b100};
        logic [31:0] vals[3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        int lat;
        bit ok;
        sub_busy   = 3'b000;
        sub_value0 = vals[0];
        sub_value1 = vals[1];
        sub_value2 = vals[2];
        for (int k = 0; k < 4; k++) begin
            expQ.push_back(trg[k] == 3'b001 ? vals[0] : trg[k] == 3'b010 ? vals[1] : vals[2]);
            sendCmd({ops[k], 28'h0000_0A5});
            nChecks++;
            if (sub_trig !== trg[k]) begin nFails++; $display("FAIL minwait_trig: got %b expected %b", sub_trig, trg[k]); end
            lat = 0;
            while (rsp_done !== 1'b1 && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            // Idle subsystem: WAIT holds for counts 1 and 2, result appears the cycle after
            nChecks++;
            if (lat != 3) begin nFails++; $display("FAIL minwait_latency: got %0d expected 3", lat); end
            waitIdle(10, ok);
        end
    endtask

    task automatic test_timeout;
        int lat;
        bit ok;
        sub_busy = 3'b100;
        expQ.push_back(32'hDEAD_0002);
        mTimeout = satInc(mTimeout);
        sendCmd(32'h6000_0000);
        nChecks++;
        if (sub_trig !== 3'b100) begin nFails++; $display("FAIL timeout_trig: got %b expected 100", sub_trig); end
        lat = 0;
        while (rsp_done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        nChecks++;
        if (lat != 17) begin nFails++; $display("FAIL timeout_latency: got %0d expected 17", lat); end
        sub_busy = 3'b000;
        waitIdle(10, ok);
        statusRead(1'b0);
        waitIdle(10, ok);
        nChecks++;
        if (!ok) begin nFails++; $display("FAIL timeout_idle: got busy expected idle"); end
    endtask

    task automatic test_badcmd;
        bit ok;
        expQ.push_back(32'hBADC_000A);
        mBad = satInc(mBad);
        sendCmd(32'hA000_0000);
        nChecks++;
        if (sub_trig !== 3'b000 || sub_cmd !== 32'h6000_0000) begin
            nFails++;
            $display("FAIL badcmd_side: got trig %b cmd %h expected 000 60000000", sub_trig, sub_cmd);
        end
        waitIdle(10, ok);
        statusRead(1'b1);
        nChecks++;
        if (sub_trig !== 3'b000 || sub_cmd !== 32'h6000_0000) begin
            nFails++;
            $display("FAIL status_side: got trig %b cmd %h expected 000 60000000", sub_trig, sub_cmd);
        end
        waitIdle(10, ok);
        statusRead(1'b0);
        waitIdle(10, ok);
    endtask

    task automatic test_overrun;
        bit ok;
        sub_value1 = 32'h1234_5678;
        sub_busy   = 3'b010;
        expQ.push_back(32'h1234_5678);
        sendCmd(32'h5000_0003);
        @(negedge clk);
        cmd_in    = 32'h2000_0000;
        cmd_valid = 1'b1;
        mOverrun  = satInc(mOverrun);
        @(negedge clk);
        cmd_valid = 1'b0;
        nChecks++;
        if (sub_trig !== 3'b000 || sub_cmd !== 32'h5000_0003 || sched_busy !== 1'b1) begin
            nFails++;
            $display("FAIL overrun_side: got trig %b cmd %h busy %b expected 000 50000003 1",
                     sub_trig, sub_cmd, sched_busy);
        end
        repeat (3) @(negedge clk);
        sub_busy = 3'b000;
        waitIdle(20, ok);
        statusRead(1'b1);
        waitIdle(10, ok);
        statusRead(1'b0);
        waitIdle(10, ok);
        nChecks++;
        if (!ok) begin nFails++; $display("FAIL overrun_idle: got busy expected idle"); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int d0;
        d0 = nDone;
        expQ.push_back(32'hBADC_000B);
        mBad = satInc(mBad);
        sendCmd(32'hB000_0000);
        cmd_in    = 32'hC000_0000;
        cmd_valid = 1'b1;
        mOverrun  = satInc(mOverrun);
        @(negedge clk);
        cmd_in = 32'hD000_0000;
        expQ.push_back(32'hBADC_000D);
        mBad = satInc(mBad);
        @(negedge clk);
        cmd_valid = 1'b0;
        waitIdle(10, ok);
        nChecks++;
        if (!ok || nDone - d0 != 2) begin
            nFails++;
            $display("FAIL b2b_done: got %0d pulses expected 2", nDone - d0);
        end
        statusRead(1'b0);
        waitIdle(10, ok);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int d0;
        sub_busy = 3'b001;
        sendCmd(32'h3000_0000);
        repeat (2) @(negedge clk);
        rest = 1'b1;
        repeat (2) @(negedge clk);
        rest = 1'b0;
        mTimeout = '0;
        mOverrun = '0;
        mBad     = '0;
        nChecks++;
        if ({sub_cmd, rsp_value} !== 64'h0 || {sub_trig, rsp_done, sched_busy} !== 5'b0) begin
            nFails++;
            $display("FAIL midreset_outputs: got %h %h %b expected 0 0 00000",
                     sub_cmd, rsp_value, {sub_trig, rsp_done, sched_busy});
        end
        d0 = nDone;
        sub_busy = 3'b000;
        repeat (5) @(negedge clk);
        nChecks++;
        if (nDone != d0 || sched_busy !== 1'b0 || rsp_value !== 32'h0) begin
            nFails++;
            $display("FAIL midreset_abort: got %0d pulses busy %b value %h expected 0 0 0",
                     nDone - d0, sched_busy, rsp_value);
        end
        sub_value0 = 32'h0000_BEEF;
        expQ.push_back(32'h0000_BEEF);
        sendCmd(32'h2000_0001);
        nChecks++;
        if (sub_trig !== 3'b001) begin nFails++; $display("FAIL midreset_trig: got %b expected 001", sub_trig); end
        waitIdle(20, ok);
        nChecks++;
        if (!ok || nDone - d0 != 1) begin
            nFails++;
            $display("FAIL midreset_new: got %0d pulses expected 1", nDone - d0);
        end
    endtask

    task automatic test_saturation;
        bit ok;
        int stuck;
        stuck = 0;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            op = 4'(8 + (i % 8));
            expQ.push_back({16'hBADC, 12'h000, op});
            mBad = satInc(mBad);
            sendCmd({op, 28'h0});
            waitIdle(10, ok);
            if (!ok) stuck++;
        end
        nChecks++;
        if (stuck != 0) begin nFails++; $display("FAIL sat_idle: got %0d stuck expected 0", stuck); end
        statusRead(1'b0);
        waitIdle(10, ok);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_routed();
        test_min_wait();
        test_timeout();
        test_badcmd();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        repeat (3) @(negedge clk);
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
